// File: rtl/scope_pkg.sv
// Shared types and default sizes for the scope trigger/capture path.
package scope_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } scope_state_e;

  // I occupies the upper half so a pair packs exactly like {i, q} in the RAM.
  typedef struct packed {
    logic [DW_DEF-1:0] i;
    logic [DW_DEF-1:0] q;
  } iq_pair_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module scope_capture_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Same-address read and write in one cycle returns the previous contents.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_capture_ctrl.sv
// Trigger/capture sequencer feeding the VGA scope display from the IFFT I/Q stream.
// Optional SCOPE_PRETRIG_EN keeps PRETRIG samples of history ahead of the trigger.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int CF          = 1,
  parameter int STEP        = 2,
  parameter int HOLD_FRAMES = 4,
  parameter int PRETRIG     = 16
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_i,
  input  logic [DW-1:0] s_q,
  input  logic          arm,
  input  logic          auto_rearm,
  input  logic          trig_src,
  input  logic [DW-1:0] trig_level,
  input  logic          frame_pulse,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_i,
  output logic [DW-1:0] rd_q,
  output logic          rd_valid,
  output logic [AW-1:0] scroll_ofs,
  output logic [1:0]    state,
  output logic          done
);

  localparam int CW = 8;
`ifdef SCOPE_PRETRIG_EN
  localparam int CAP_LEN = DEPTH - PRETRIG;
  localparam logic [AW-1:0] PRE_A = AW'(PRETRIG);
`else
  localparam int CAP_LEN = DEPTH;
`endif
  localparam logic [AW-1:0] CAP_LAST = AW'(CAP_LEN - 1);

  if ((DEPTH != (1 << AW)) || (PRETRIG >= DEPTH) || (CF < 1) || (CF > 256) ||
      (HOLD_FRAMES > 255)) begin : g_bad_params
    $error("scope_capture_ctrl: inconsistent DEPTH/AW/PRETRIG/CF/HOLD_FRAMES");
  end

  scope_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, cnt_q, scroll_ofs_q, base, rd_addr;
  logic [CW-1:0] frame_cnt_q, hold_cnt_q;
  logic [DW-1:0] prev_q, x;
  logic          prev_valid_q, done_q, rd_valid_q;
  logic          pre_ok, trig_hit, last_wr, hold_reached, rearm, enter_armed, we;
  logic [2*DW-1:0] rd_data;

`ifdef SCOPE_PRETRIG_EN
  logic [AW-1:0] base_q;
  assign base   = base_q;
  assign pre_ok = (cnt_q >= PRE_A);
`else
  assign base   = '0;
  assign pre_ok = 1'b1;
`endif

  assign x            = trig_src ? s_q : s_i;
  assign trig_hit     = prev_valid_q && pre_ok &&
                        ($signed(prev_q) < $signed(trig_level)) &&
                        ($signed(x) >= $signed(trig_level));
  // cnt_q counts samples stored since the trigger, so it marks the final write.
  assign last_wr      = s_valid && (cnt_q == CAP_LAST);
  assign hold_reached = (hold_cnt_q >= CW'(HOLD_FRAMES));
  assign rearm        = arm || (auto_rearm && hold_reached);
  assign rd_addr      = rd_idx + base + scroll_ofs_q;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (s_valid && trig_hit) state_d = CAPTURE;
      CAPTURE: if (last_wr) state_d = HOLD;
      HOLD:    if (rearm) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we          = 1'b0;
    enter_armed = 1'b0;
    unique case (state_q)
      IDLE:    enter_armed = arm;
`ifdef SCOPE_PRETRIG_EN
      ARMED:   we = s_valid;
`else
      ARMED:   we = s_valid && trig_hit;
`endif
      CAPTURE: we = s_valid;
      HOLD:    enter_armed = rearm;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      scroll_ofs_q <= '0;
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
`ifdef SCOPE_PRETRIG_EN
      base_q       <= '0;
`endif
    end else begin
      done_q     <= (state_q == CAPTURE) && last_wr;
      rd_valid_q <= rd_en && (state_q == HOLD);
      if (we) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (enter_armed) begin
        wr_ptr_q     <= '0;
        cnt_q        <= '0;
        scroll_ofs_q <= '0;
        frame_cnt_q  <= '0;
        hold_cnt_q   <= '0;
        prev_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          ARMED: if (s_valid) begin
            prev_q       <= x;
            prev_valid_q <= 1'b1;
            if (trig_hit) begin
              cnt_q <= AW'(1);
`ifdef SCOPE_PRETRIG_EN
              base_q <= wr_ptr_q - PRE_A;
            end else if (cnt_q < PRE_A) begin
              cnt_q <= cnt_q + AW'(1);
`endif
            end
          end
          CAPTURE: if (s_valid) begin
            cnt_q <= cnt_q + AW'(1);
          end
          HOLD: if (frame_pulse) begin
            if (frame_cnt_q == CW'(CF - 1)) begin
              frame_cnt_q  <= '0;
              scroll_ofs_q <= scroll_ofs_q + AW'(STEP);
            end else begin
              frame_cnt_q <= frame_cnt_q + CW'(1);
            end
            if (!hold_reached) begin
              hold_cnt_q <= hold_cnt_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  scope_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (2 * DW)
  ) u_ram (
    .clk_i   (CLOCK_50),
    .rst_ni  (rst_n),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({s_i, s_q}),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rd_i       = rd_data[2*DW-1:DW];
  assign rd_q       = rd_data[DW-1:0];
  assign rd_valid   = rd_valid_q;
  assign scroll_ofs = scroll_ofs_q;
  assign state      = state_q;
  assign done       = done_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl (default build): read responses are
// queued at issue time and checked by a monitor whenever rd_valid is presented.
module tb_scope_capture_ctrl;
  import scope_pkg::*;

  localparam int DW = DW_DEF;
  localparam int AW = AW_DEF;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n;
  logic          s_valid, arm, auto_rearm, trig_src, frame_pulse, rd_en;
  logic [DW-1:0] s_i, s_q, trig_level;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_i, rd_q;
  logic          rd_valid, done;
  logic [AW-1:0] scroll_ofs;
  logic [1:0]    state;

  int compareCnt = 0;
  int failCnt    = 0;
  int doneCnt    = 0;
  iq_pair_t expQ[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  scope_capture_ctrl dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_i         (s_i),
    .s_q         (s_q),
    .arm         (arm),
    .auto_rearm  (auto_rearm),
    .trig_src    (trig_src),
    .trig_level  (trig_level),
    .frame_pulse (frame_pulse),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_i        (rd_i),
    .rd_q        (rd_q),
    .rd_valid    (rd_valid),
    .scroll_ofs  (scroll_ofs),
    .state       (state),
    .done        (done)
  );

  function automatic iq_pair_t mkPair(input int i, input int q);
    iq_pair_t p;
    p.i = DW'(i);
    p.q = DW'(q);
    return p;
  endfunction

  // Monitor: counts done pulses and checks every presented read against the queue.
  always @(negedge CLOCK_50) begin
    iq_pair_t exp;
    if (done === 1'b1) doneCnt++;
    if (rd_valid === 1'b1) begin
      compareCnt++;
      if (expQ.size() == 0) begin
        failCnt++;
        $display("[TB] FAIL rd_unexpected: got rd_valid=1 data %h, required no read", {rd_i, rd_q});
      end else begin
        exp = expQ.pop_front();
        if ({rd_i, rd_q} !== exp) begin
          failCnt++;
          $display("[TB] FAIL rd_data: got %h, required %h", {rd_i, rd_q}, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCnt++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus, then inputs return to idle.
  task automatic applyStimulus(input logic v, input int si, input int sq, input logic a,
                               input logic fp, input logic re, input int idx);
    s_valid     = v;
    s_i         = DW'(si);
    s_q         = DW'(sq);
    arm         = a;
    frame_pulse = fp;
    rd_en       = re;
    rd_idx      = AW'(idx);
    tick();
    s_valid     = 1'b0;
    arm         = 1'b0;
    frame_pulse = 1'b0;
    rd_en       = 1'b0;
  endtask

  task automatic sendSample(input int si, input int sq);
    applyStimulus(1'b1, si, sq, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic issueRead(input int idx, input int ei, input int eq);
    expQ.push_back(mkPair(ei, eq));
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, idx);
    checkOutput("rd_valid_latency", 32'(rd_valid), 32'd1);
  endtask

  task automatic pulseFrame();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; arm = 1'b0; auto_rearm = 1'b0; trig_src = 1'b0;
    frame_pulse = 1'b0; rd_en = 1'b0; rd_idx = '0; s_i = '0; s_q = '0; trig_level = '0;
    repeat (3) tick();
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_scroll", 32'(scroll_ofs), 32'd0);
    checkOutput("reset_rd_i", 32'(rd_i), 32'd0);
    checkOutput("reset_rd_q", 32'(rd_q), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_hold", 32'(state), 32'd0);

    // Capture A: ramp -10,-5,0,1,2.. triggers on the 0 crossing.
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("arm_to_armed", 32'(state), 32'd1);
    sendSample(-10, 'h11);
    checkOutput("a_no_trig_1", 32'(state), 32'd1);
    sendSample(-5, 'h22);
    checkOutput("a_no_trig_2", 32'(state), 32'd1);
    sendSample(0, 'h55);
    checkOutput("a_trig", 32'(state), 32'd2);
    for (int c = 1; c < 63; c++) begin
      if (c == 30) repeat (3) tick();
      sendSample(c, c ^ 'h55);
    end
    checkOutput("a_before_last_state", 32'(state), 32'd2);
    checkOutput("a_before_last_done", 32'(doneCnt), 32'd0);
    sendSample(63, 'h6A);
    checkOutput("a_hold", 32'(state), 32'd3);
    tick();
    checkOutput("a_done_count", 32'(doneCnt), 32'd1);
    checkOutput("a_done_one_cycle", 32'(done), 32'd0);
    issueRead(0, 0, 'h55);
    issueRead(5, 5, 'h50);
    issueRead(63, 63, 'h6A);

    // 33 frames at STEP=2 wrap the scroll offset to 2.
    for (int f = 0; f < 33; f++) pulseFrame();
    checkOutput("scroll_wrap", 32'(scroll_ofs), 32'd2);
    issueRead(63, 1, 'h54);
    issueRead(0, 2, 'h57);

    // Capture B: the first sample after arming never triggers.
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("b_armed", 32'(state), 32'd1);
    checkOutput("b_scroll_clear", 32'(scroll_ofs), 32'd0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    checkOutput("armed_read_invalid", 32'(rd_valid), 32'd0);
    sendSample(20, 1);
    checkOutput("b_first_no_trig", 32'(state), 32'd1);
    sendSample(-1, 2);
    checkOutput("b_drop_no_trig", 32'(state), 32'd1);
    sendSample(3, 7);
    checkOutput("b_trig", 32'(state), 32'd2);
    for (int c = 1; c < 64; c++) sendSample(c + 50, c);
    checkOutput("b_hold", 32'(state), 32'd3);
    tick();
    checkOutput("b_done_count", 32'(doneCnt), 32'd2);
    issueRead(0, 3, 7);
    issueRead(1, 51, 1);

    // Auto re-arm after 4 frames; a read alongside a scroll step uses the old offset.
    auto_rearm = 1'b1;
    expQ.push_back(mkPair(3, 7));
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("scroll_after_read", 32'(scroll_ofs), 32'd2);
    tick();
    pulseFrame();
    pulseFrame();
    checkOutput("hold_before_4th", 32'(state), 32'd3);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("hold_at_4th", 32'(state), 32'd3);
    checkOutput("scroll_at_4th", 32'(scroll_ofs), 32'd8);
    tick();
    checkOutput("auto_rearm_state", 32'(state), 32'd1);
    checkOutput("auto_rearm_scroll", 32'(scroll_ofs), 32'd0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3);
    checkOutput("rearm_read_invalid", 32'(rd_valid), 32'd0);

    // Abort a capture with wr_ptr at 30 via a one-cycle reset.
    auto_rearm = 1'b0;
    sendSample(-10, 0);
    sendSample(0, 0);
    checkOutput("c_trig", 32'(state), 32'd2);
    for (int c = 1; c < 30; c++) sendSample(c + 20, c);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_scroll", 32'(scroll_ofs), 32'd0);
    checkOutput("abort_rd_i", 32'(rd_i), 32'd0);
    for (int c = 0; c < 40; c++) sendSample(c, c);
    checkOutput("abort_stays_idle", 32'(state), 32'd0);
    checkOutput("abort_no_done", 32'(doneCnt), 32'd2);

    // Capture D after the abort starts fresh at address 0.
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    sendSample(-3, 0);
    sendSample(4, 9);
    checkOutput("d_trig", 32'(state), 32'd2);
    for (int c = 1; c < 64; c++) sendSample(-c, c + 1);
    checkOutput("d_hold", 32'(state), 32'd3);
    tick();
    checkOutput("d_done_count", 32'(doneCnt), 32'd3);
    issueRead(0, 4, 9);
    issueRead(40, -40, 41);
    issueRead(63, -63, 64);

    repeat (3) tick();
    checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
